// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: machine widths, reset PC and the fetch FIFO payload.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; head, count and flags come straight from registers.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_empty,
    output logic         o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_do_push;
    logic          w_do_pop;
    logic [CW-1:0] w_count_nxt;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        w_do_pop    = i_pop && !r_empty;
        w_do_push   = i_push && (!r_full || w_do_pop);
        w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited word fetches into a small FIFO, with redirect flush and misaligned-target fault.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    output logic            o_valid,
    output logic [ILEN-1:0] o_opcode,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_addr,
    output logic            o_fault
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;

    logic [0:0]      w_state_nxt;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [XLEN-1:0] w_resp_pc_nxt;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW-1:0]   w_discard_nxt;

    logic            w_credit_ok;
    logic            w_accept;
    logic            w_resp_dec;
    logic            w_keep;
    fetch_entry_t    w_push_data;
    fetch_entry_t    w_head;
    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic            w_full;

    // Discarded responses are still counted in r_outstanding, so the credit covers them too.
    assign w_credit_ok = !w_full &&
                         ((SW'(r_outstanding) + SW'(w_count)) < SW'(DEPTH));
    assign o_imem_req  = i_rst_n && (r_state == ST_RUN) && !i_redirect && w_credit_ok;
    assign o_imem_addr = r_fetch_pc;
    assign w_accept    = o_imem_req && i_imem_ready;
    assign w_resp_dec  = i_imem_rvalid && (r_outstanding != '0);
    assign w_keep      = i_imem_rvalid && (r_discard == '0) && !i_redirect &&
                         (r_state == ST_RUN);
    assign w_push_data = '{pc: r_resp_pc, instr: i_imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_keep),
        .i_data  (w_push_data),
        .i_pop   (i_ready),
        .i_flush (i_redirect),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Next-state: a redirect overrides every other update and re-arms the discard counter.
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_resp_pc_nxt     = r_resp_pc;
        w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(w_resp_dec);
        w_discard_nxt     = r_discard;
        if (i_redirect) begin
            w_fetch_pc_nxt = i_redirect_addr;
            w_resp_pc_nxt  = i_redirect_addr;
            w_discard_nxt  = r_outstanding - CW'(w_resp_dec);
            w_state_nxt    = (i_redirect_addr[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
        end else begin
            if (w_accept) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
            if (w_keep) begin
                w_resp_pc_nxt = r_resp_pc + 32'd4;
            end
            if (i_imem_rvalid && (r_discard != '0)) begin
                w_discard_nxt = r_discard - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    assign o_valid  = !w_empty;
    assign o_opcode = w_head.instr;
    assign o_pc     = w_head.pc;
    assign o_fault  = (r_state == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with random latency, stream-level reference model, directed and table cases.
module tb_instr_fetch;
    import rv32i_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_opcode;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic        o_fault;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ready    (i_imem_ready),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .o_valid         (o_valid),
        .o_opcode        (o_opcode),
        .o_pc            (o_pc),
        .i_ready         (i_ready),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .o_fault         (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] addr;
        logic        exp_fault;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    mreq_t       mq[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_q[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rdy_rand = 1'b0;
    bit          mem_const = 1'b0;
    int          tot_pops = 0;

    logic [31:0] exp_pc, exp_req;
    bit          exp_fault, flushed, hold_pend;
    logic [31:0] hold_pc, hold_op;
    logic        s_req, s_valid, s_fault, s_rvalid;
    logic [31:0] s_addr, s_pc, s_op;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return mem_const ? 32'h0000_0013 : ((a * 32'd7) ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive memory, sample and check at negedge, update models at posedge.
    task automatic tick();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = data_of(mq[0].addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 32'h0;
        end
        i_imem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge i_clk);
        s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid;
        s_pc = o_pc; s_op = o_opcode; s_fault = o_fault; s_rvalid = i_imem_rvalid;
        chk("fault_flag", 32'(o_fault), 32'(exp_fault));
        if (exp_fault) begin
            chk("fault_req", 32'(o_imem_req), 32'd0);
            chk("fault_valid", 32'(o_valid), 32'd0);
        end
        if (flushed) chk("flush_valid", 32'(o_valid), 32'd0);
        if (hold_pend) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_pc", o_pc, hold_pc);
            chk("hold_op", o_opcode, hold_op);
        end
        if (o_imem_req) chk("req_addr", o_imem_addr, exp_req);
        if (o_valid && i_ready) begin
            chk("pop_pc", o_pc, exp_pc);
            chk("pop_op", o_opcode, data_of(exp_pc));
        end
        chk("credit", 32'(mq.size() <= DEPTH), 32'd1);
        @(posedge i_clk);
        if (s_req && i_imem_ready) begin
            mq.push_back('{s_addr, cyc + int'($urandom_range(lat_min, lat_max))});
            acc_q.push_back(s_addr);
            exp_req = exp_req + 32'd4;
        end
        if (s_rvalid) void'(mq.pop_front());
        hold_pend = s_valid && !i_ready && !i_redirect;
        hold_pc = s_pc; hold_op = s_op;
        if (i_redirect) begin
            exp_pc = i_redirect_addr; exp_req = i_redirect_addr;
            exp_fault = (i_redirect_addr[1:0] != 2'b00);
            flushed = 1'b1;
            acc_q.delete(); pop_q.delete();
        end else begin
            flushed = 1'b0;
            if (s_valid && i_ready) begin
                pop_q.push_back(s_pc);
                exp_pc = exp_pc + 32'd4;
                tot_pops++;
            end
        end
        cyc++;
        #1;
        i_redirect = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_opcode", o_opcode, 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        i_imem_rvalid = 1'b0; i_redirect = 1'b0;
        mq.delete(); acc_q.delete(); pop_q.delete();
        exp_pc = RESET_PC; exp_req = RESET_PC;
        exp_fault = 1'b0; flushed = 1'b0; hold_pend = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cyc = 1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if (s_valid) seen = 1'b1;
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "_pc"}, s_pc, pc);
            chk({name, "_op"}, s_op, data_of(pc));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        i_rst_n = 1'b1; i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_ready = 1'b1; i_redirect = 1'b0; i_redirect_addr = '0;
        #2;

        // Basic stream: requests 0,4,...; first valid in cycle 3.
        mem_const = 1'b1;
        do_reset();
        tick(); chk("c1_req", 32'(s_req), 32'd1); chk("c1_addr", s_addr, 32'h0);
        chk("c1_valid", 32'(s_valid), 32'd0);
        tick(); chk("c2_valid", 32'(s_valid), 32'd0); chk("c2_addr", s_addr, 32'h4);
        tick(); chk("c3_valid", 32'(s_valid), 32'd1); chk("c3_pc", s_pc, 32'h0);
        chk("c3_op", s_op, 32'h13);
        repeat (8) tick();
        chk("seq_n", 32'(pop_q.size() >= 3), 32'd1);
        if (pop_q.size() >= 3) begin
            chk("seq_pc1", pop_q[1], 32'h4);
            chk("seq_pc2", pop_q[2], 32'h8);
        end
        mem_const = 1'b0;

        // Decoder stall: only DEPTH fetches, head held, then resume.
        do_reset();
        i_ready = 1'b0;
        repeat (10) tick();
        chk("stall_acc", 32'(acc_q.size()), 32'(DEPTH));
        chk("stall_req", 32'(s_req), 32'd0);
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_pc", s_pc, 32'h0);
        i_ready = 1'b1;
        repeat (20) tick();
        chk("resume_n", 32'(pop_q.size() >= 5), 32'd1);
        if (pop_q.size() > 0) chk("resume_first", pop_q[0], 32'h0);

        // Latency 3 with two in flight, redirect drops both.
        lat_min = 3; lat_max = 3;
        do_reset();
        tick(); tick();
        i_redirect = 1'b1; i_redirect_addr = 32'h100;
        tick(); chk("l3_req", 32'(s_req), 32'd0);
        wait_valid("l3", 32'h100);
        if (acc_q.size() > 0) chk("l3_acc0", acc_q[0], 32'h100);

        // Redirect coinciding with a response (and a pop for latency 1).
        for (int l = 1; l <= 2; l++) begin
            lat_min = l; lat_max = l;
            do_reset();
            tick(); tick();
            i_redirect = 1'b1; i_redirect_addr = 32'h300;
            tick(); chk("rr_rvalid", 32'(s_rvalid), 32'd1);
            tick(); chk("rr_empty", 32'(s_valid), 32'd0);
            wait_valid("rr", 32'h300);
            if (acc_q.size() > 0) chk("rr_acc0", acc_q[0], 32'h300);
        end

        // Redirect table: aligned targets, misaligned faults, address wrap.
        vecs[0] = '{32'h0000_0100, 1'b0, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0102, 1'b1, 32'h0, 32'h0};
        vecs[2] = '{32'h0000_0203, 1'b1, 32'h0, 32'h0};
        vecs[3] = '{32'h0000_0200, 1'b0, 32'h0000_0200, 32'h0000_0204};
        vecs[4] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[5] = '{32'h0000_1001, 1'b1, 32'h0, 32'h0};
        vecs[6] = '{32'h0000_0040, 1'b0, 32'h0000_0040, 32'h0000_0044};
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) tick();
        foreach (vecs[v]) begin
            i_redirect = 1'b1; i_redirect_addr = vecs[v].addr;
            tick();
            repeat (8) tick();
            chk("tbl_fault", 32'(s_fault), 32'(vecs[v].exp_fault));
            if (vecs[v].exp_fault) begin
                chk("tbl_f_acc", 32'(acc_q.size()), 32'd0);
                chk("tbl_f_valid", 32'(s_valid), 32'd0);
            end else begin
                chk("tbl_acc_n", 32'(acc_q.size() >= 2), 32'd1);
                chk("tbl_pop_n", 32'(pop_q.size() >= 1), 32'd1);
                if (acc_q.size() >= 2) begin
                    chk("tbl_a0", acc_q[0], vecs[v].exp_a0);
                    chk("tbl_a1", acc_q[1], vecs[v].exp_a1);
                end
                if (pop_q.size() >= 1) chk("tbl_pop0", pop_q[0], vecs[v].exp_a0);
            end
        end

        // Randomized traffic against the stream model.
        rdy_rand = 1'b1; lat_min = 1; lat_max = 4;
        do_reset();
        tot_pops = 0;
        for (int n = 0; n < 3000; n++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                int unsigned r = $urandom_range(0, 7);
                i_redirect = 1'b1;
                if (r == 0)      i_redirect_addr = $urandom | 32'h1;
                else if (r == 1) i_redirect_addr = 32'hFFFF_FFF8;
                else             i_redirect_addr = $urandom & 32'hFFFF_FFFC;
            end
            tick();
        end
        chk("rand_progress", 32'(tot_pops > 100), 32'd1);

        // Asynchronous reset mid-burst, then restart from RESET_PC.
        i_ready = 1'b1;
        #3;
        do_reset();
        tick();
        chk("post_rst_req", 32'(s_req), 32'd1);
        chk("post_rst_addr", s_addr, RESET_PC);
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
